dot_prod_vector_server: RTL and testbench
=========================================

Name: dot_prod_vector_server

Overview:
- Responder side of the dot_prod column-fetch interface.
- Holds the input vector in two ping-pong register banks and answers the engine's colAddress with inputVector in the same cycle (combinational read).
- An upstream stage streams the next vector into the shadow bank while the engine consumes the active bank.
- Banks swap on the engine's dataReady pulse.

Parameters:
NCOL, 16, vector length; number of colAddress values served
QN, 6, integer bits of fixed-point word
QM, 11, fractional bits of fixed-point word
BITWIDTH, QN+QM+1, word width (signed)
ADDR_BITWIDTH, 4, colAddress width; must satisfy 2^ADDR_BITWIDTH >= NCOL

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
loadValid  input  1  upstream word valid
loadData  input  BITWIDTH  upstream word, signed, element order 0..NCOL-1
loadReady  output  1  shadow bank can accept a word
colAddress  input  ADDR_BITWIDTH  element index requested by engine
dataReady  input  1  engine end-of-pass pulse (one cycle high)
inputVector  output  BITWIDTH  signed element of active bank at colAddress
vectorValid  output  1  active bank holds a complete vector
underrun  output  1  one-cycle pulse: dataReady seen while shadow bank not full

Behaviour:
- Reset (reset=0, asynchronous) clears:
  - all control: readBank=0, write index wIdx=0, shadow state FILL, active state EMPTY.
  - outputs: loadReady=1 after release, vectorValid=0, underrun=0, inputVector=0.
  - Bank contents are not cleared; they are masked by vectorValid=0.
- Shadow bank FSM (FILL/FULL):
  - FILL: loadReady=1. A word is accepted when loadValid && loadReady; it is written to bank[~readBank][wIdx] and wIdx increments.
  - When the word at wIdx==NCOL-1 is accepted, go to FULL and set wIdx=0.
  - FULL: loadReady=0. Stay until swap.
- Active bank FSM (EMPTY/ACTIVE):
  - EMPTY: vectorValid=0, inputVector=0.
  - The first swap happens automatically on the edge after the shadow bank becomes FULL; dataReady is not required.
  - ACTIVE: vectorValid=1.
- Swap condition while ACTIVE: dataReady==1 and shadowFull, where shadowFull = FULL state OR the final word (wIdx==NCOL-1) is accepted in the same cycle.
- Swap action (at the clock edge):
  - readBank toggles.
  - The shadow state returns to FILL.
  - The engine's next colAddress=0 therefore reads the new vector.
- Underrun: dataReady==1 while ACTIVE and not shadowFull. The active bank is kept; the engine recomputes the same vector. underrun pulses high for exactly one cycle (registered, asserted the cycle after dataReady).
- Read path: inputVector = bank[readBank][colAddress], purely combinational, no added latency.
  - Outputs 0 when vectorValid=0 or colAddress >= NCOL.
- Loading into the shadow bank never disturbs inputVector.
- dataReady while EMPTY: ignored, no underrun.
- Throughput: one word per cycle on the load side; NCOL cycles minimum to fill a bank.

Optional Feature:
VECSERVER_STATS_EN
- Defined: adds output ports swapCount[15:0] and underrunCount[15:0].
  - Both reset to 0 and saturate at 16'hFFFF.
  - swapCount increments on every swap, including the first automatic one.
  - underrunCount increments on every underrun pulse.
- Undefined: neither the ports nor the counters exist; all other behaviour is identical.

Test Plan:
- After reset release, stream 0..15 (loadData=k<<QM) with loadValid always 1:
  - loadReady=1 for 16 cycles, then 0.
  - vectorValid rises 1 cycle after the 16th accept.
  - colAddress=5 gives inputVector=5<<QM.
- Active vector A, shadow loaded with B, pulse dataReady:
  - The next edge swaps; colAddress=3 returns B[3].
  - loadReady returns to 1.
  - No underrun.
- Active A, shadow only 10 words loaded, pulse dataReady:
  - underrun=1 for one cycle; inputVector still A.
  - The shadow load continues from wIdx=10.
- Final shadow word accepted in the same cycle dataReady=1: a swap occurs and the new vector is complete and correct.
- colAddress=15 with NCOL=12, and any address before the first vector completes: inputVector=0.
- Assert reset=0 mid-fill (wIdx=7) asynchronously, without a clock edge:
  - Outputs clear immediately; vectorValid=0.
  - A reload starts at element 0.
  - With VECSERVER_STATS_EN defined, the counters read 0.

Source files
------------

// File: rtl/dot_prod_vector_server.sv
`timescale 1ns / 1ps
// dot_prod_vector_server
//
// Responder side of the dot_prod column-fetch interface. The input vector is
// held in two ping-pong register banks: the engine reads the active bank
// combinationally by colAddress while an upstream stage streams the next
// vector into the shadow bank. The banks swap on the engine's end-of-pass
// pulse (dataReady). The very first swap happens automatically once the
// shadow bank has filled.
//
// Ports:
//   clk           clock
//   reset         asynchronous, active-low reset
//   loadValid     upstream word valid
//   loadData      upstream word (signed, element order 0..NCOL-1)
//   loadReady     shadow bank can accept a word
//   colAddress    element index requested by the engine
//   dataReady     engine end-of-pass pulse (one cycle high)
//   inputVector   active-bank element at colAddress (0 when invalid/out of range)
//   vectorValid   active bank holds a complete vector
//   underrun      one-cycle pulse: dataReady seen while the shadow bank was not full
//   fsmState      {active FSM is ACTIVE, shadow FSM is FULL}
//
// Load handshake: a word transfers on a rising clk edge where loadValid and
// loadReady are both high. loadValid may be raised without waiting for
// loadReady; loadData must be stable while loadValid is high.
//
// Optional build macro VECSERVER_STATS_EN adds two saturating 16-bit
// counters on extra outputs:
//   swapCount      bank swaps, including the first automatic one
//   underrunCount  underrun pulses

module dot_prod_vector_server #(
    parameter int NCOL          = 16,
    parameter int QN            = 6,
    parameter int QM            = 11,
    parameter int BITWIDTH      = QN + QM + 1,
    parameter int ADDR_BITWIDTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       loadValid,
    input  logic signed [BITWIDTH-1:0] loadData,
    output logic                       loadReady,
    input  logic [ADDR_BITWIDTH-1:0]   colAddress,
    input  logic                       dataReady,
    output logic signed [BITWIDTH-1:0] inputVector,
    output logic                       vectorValid,
    output logic                       underrun,
    output logic [1:0]                 fsmState
`ifdef VECSERVER_STATS_EN
    ,
    output logic [15:0]                swapCount,
    output logic [15:0]                underrunCount
`endif
);

    // Reject parameter sets the address bus cannot cover.
    if (BITWIDTH != QN + QM + 1 || (2 ** ADDR_BITWIDTH) < NCOL) begin : g_bad_params
        $error("dot_prod_vector_server: inconsistent parameters");
    end

    typedef enum logic { FILL  = 1'b0, FULL   = 1'b1 } shadow_state_t;
    typedef enum logic { EMPTY = 1'b0, ACTIVE = 1'b1 } active_state_t;

    localparam logic [ADDR_BITWIDTH-1:0] LAST_IDX = ADDR_BITWIDTH'(NCOL - 1);

    logic [BITWIDTH-1:0]      mem [0:1][0:NCOL-1];
    logic                     readBank;
    logic                     writeBank;
    logic [ADDR_BITWIDTH-1:0] wIdx;
    shadow_state_t            shadowState;
    active_state_t            activeState;

    logic accept;
    logic lastAccept;
    logic shadowFull;
    logic swap;
    logic underrunHit;
    logic addrOk;

    assign writeBank  = ~readBank;
    assign loadReady  = (shadowState == FILL);
    assign accept     = loadValid && loadReady;
    assign lastAccept = accept && (wIdx == LAST_IDX);
    // A final word landing in the same cycle as dataReady still counts as full.
    assign shadowFull = (shadowState == FULL) || lastAccept;

    // While EMPTY the swap is automatic, one edge after the shadow reached FULL.
    assign swap        = (activeState == EMPTY) ? (shadowState == FULL)
                                                : (dataReady && shadowFull);
    assign underrunHit = (activeState == ACTIVE) && dataReady && !shadowFull;

    assign vectorValid = (activeState == ACTIVE);
    assign fsmState    = {activeState == ACTIVE, shadowState == FULL};

    assign addrOk      = (32'(colAddress) < NCOL);
    assign inputVector = (vectorValid && addrOk) ? mem[readBank][colAddress]
                                                 : '0;

    // Bank storage is intentionally not reset; vectorValid masks stale data.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[writeBank][wIdx] <= loadData;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            readBank    <= 1'b0;
            wIdx        <= '0;
            shadowState <= FILL;
            activeState <= EMPTY;
            underrun    <= 1'b0;
        end else begin
            underrun <= underrunHit;

            if (accept) begin
                wIdx <= lastAccept ? '0 : wIdx + 1'b1;
            end

            // Swap wins over the last-word transition: the freshly written
            // word belongs to the bank that becomes active on this edge.
            if (swap) begin
                readBank    <= ~readBank;
                shadowState <= FILL;
                activeState <= ACTIVE;
            end else if (lastAccept) begin
                shadowState <= FULL;
            end
        end
    end

`ifdef VECSERVER_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            swapCount     <= '0;
            underrunCount <= '0;
        end else begin
            if (swap && swapCount != 16'hFFFF) begin
                swapCount <= swapCount + 16'd1;
            end
            if (underrunHit && underrunCount != 16'hFFFF) begin
                underrunCount <= underrunCount + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dot_prod_vector_server.sv
`timescale 1ns / 1ps
// Directed bench for dot_prod_vector_server: a default (NCOL=16) instance
// plus an NCOL=12 instance for the out-of-range address case.

module tb_dot_prod_vector_server;

    localparam int QM = 11;
    localparam int BW = 18;
    localparam int AW = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // ---------------- NCOL=16 instance ----------------
    logic          loadValid;
    logic [BW-1:0] loadData;
    logic          loadReady;
    logic [AW-1:0] colAddress;
    logic          dataReady;
    logic [BW-1:0] inputVector;
    logic          vectorValid;
    logic          underrun;
    logic [1:0]    fsmState;

    // ---------------- NCOL=12 instance ----------------
    logic          ld12Valid;
    logic [BW-1:0] ld12Data;
    logic          ld12Ready;
    logic [AW-1:0] col12;
    logic          dr12;
    logic [BW-1:0] iv12;
    logic          vv12;
    logic          ur12;
    logic [1:0]    st12;

`ifdef VECSERVER_STATS_EN
    logic [15:0] swapCount;
    logic [15:0] underrunCount;
    logic [15:0] swapCount12;
    logic [15:0] underrunCount12;
`endif

    dot_prod_vector_server u_dut (
        .clk         (clk),
        .reset       (reset),
        .loadValid   (loadValid),
        .loadData    (loadData),
        .loadReady   (loadReady),
        .colAddress  (colAddress),
        .dataReady   (dataReady),
        .inputVector (inputVector),
        .vectorValid (vectorValid),
        .underrun    (underrun),
        .fsmState    (fsmState)
`ifdef VECSERVER_STATS_EN
        ,
        .swapCount     (swapCount),
        .underrunCount (underrunCount)
`endif
    );

    dot_prod_vector_server #(.NCOL(12)) u_dut12 (
        .clk         (clk),
        .reset       (reset),
        .loadValid   (ld12Valid),
        .loadData    (ld12Data),
        .loadReady   (ld12Ready),
        .colAddress  (col12),
        .dataReady   (dr12),
        .inputVector (iv12),
        .vectorValid (vv12),
        .underrun    (ur12),
        .fsmState    (st12)
`ifdef VECSERVER_STATS_EN
        ,
        .swapCount     (swapCount12),
        .underrunCount (underrunCount12)
`endif
    );

    // ---------------- scoreboard ----------------
    int tests_run    = 0;
    int tests_failed = 0;
    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] va[16], vb[16], vc[16], vd[16], ve[16], vt[12];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [BW-1:0] d);
        loadValid = 1'b1;
        loadData  = d;
        step();
        loadValid = 1'b0;
    endtask

    task automatic pulse_ready();
        dataReady = 1'b1;
        step();
        dataReady = 1'b0;
    endtask

    // Reads every address of the active bank against the queued vector.
    task automatic sweep(input string tag);
        for (int a = 0; a < 16; a++) begin
            colAddress = AW'(a);
            #1;
            check(tag, inputVector, exp_q.pop_front());
        end
        step();
    endtask

    task automatic push_vec(input logic [BW-1:0] v[16]);
        for (int k = 0; k < 16; k++) exp_q.push_back(v[k]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 16; k++) begin
            va[k] = BW'(k << QM);
            vb[k] = BW'(-(k * 37 + 5));
            vc[k] = BW'(k * 100 + 1);
            vd[k] = BW'(k * 11 + 9);
            ve[k] = BW'(k * 513 + 7);
        end
        for (int k = 0; k < 12; k++) vt[k] = BW'((k * 3 + 1) << QM);

        reset      = 1'b0;
        loadValid  = 1'b0;
        loadData   = '0;
        colAddress = '0;
        dataReady  = 1'b0;
        ld12Valid  = 1'b0;
        ld12Data   = '0;
        col12      = '0;
        dr12       = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();

        // Reset state
        check("rst_loadReady", loadReady, 1);
        check("rst_vectorValid", vectorValid, 0);
        check("rst_underrun", underrun, 0);
        check("rst_inputVector", inputVector, 0);
        check("rst_fsmState", fsmState, 0);
`ifdef VECSERVER_STATS_EN
        check("rst_swapCount", swapCount, 0);
        check("rst_underrunCount", underrunCount, 0);
`endif

        // First fill: A[k] = k<<QM, automatic first swap
        colAddress = 4'd3;
        for (int k = 0; k < 16; k++) begin
            #0;
            check("fill_a_loadReady", loadReady, 1);
            check("fill_a_iv_before_valid", inputVector, 0);
            load_word(va[k]);
        end
        check("fill_a_vv_lag", vectorValid, 0);
        check("fill_a_loadReady_full", loadReady, 0);
        check("fill_a_state_full", fsmState, 2'b01);
        step();
        check("fill_a_vv_rise", vectorValid, 1);
        check("fill_a_loadReady_back", loadReady, 1);
        colAddress = 4'd5;
        #1;
        check("fill_a_addr5", inputVector, 5 << QM);
        step();
        push_vec(va);
        sweep("sweep_a");

        // Shadow gets B while A stays visible, then a normal swap
        colAddress = 4'd7;
        for (int k = 0; k < 16; k++) begin
            #0;
            check("load_b_iv_stable", inputVector, va[7]);
            load_word(vb[k]);
        end
        check("load_b_loadReady_full", loadReady, 0);
        check("load_b_vv", vectorValid, 1);
        pulse_ready();
        colAddress = 4'd3;
        #1;
        check("swap_b_addr3", inputVector, vb[3]);
        check("swap_b_loadReady", loadReady, 1);
        check("swap_b_underrun", underrun, 0);
        step();
        check("swap_b_underrun_later", underrun, 0);
        push_vec(vb);
        sweep("sweep_b");

        // Underrun: only 10 words of C in the shadow
        for (int k = 0; k < 10; k++) load_word(vc[k]);
        pulse_ready();
        colAddress = 4'd2;
        #1;
        check("underrun_pulse", underrun, 1);
        check("underrun_iv_kept", inputVector, vb[2]);
        check("underrun_loadReady", loadReady, 1);
        step();
        check("underrun_one_cycle", underrun, 0);
        check("underrun_iv_still_b", inputVector, vb[2]);

        // Resume from element 10; final word lands with dataReady
        for (int k = 10; k < 15; k++) load_word(vc[k]);
        dataReady = 1'b1;
        load_word(vc[15]);
        dataReady = 1'b0;
        check("same_cycle_swap_loadReady", loadReady, 1);
        check("same_cycle_swap_vv", vectorValid, 1);
        check("same_cycle_swap_underrun", underrun, 0);
        push_vec(vc);
        sweep("sweep_c");

        // NCOL=12 instance: out-of-range and pre-valid addresses read 0
        col12 = 4'd15;
        #1;
        check("n12_addr15_before_valid", iv12, 0);
        col12 = 4'd0;
        #1;
        check("n12_addr0_before_valid", iv12, 0);
        for (int k = 0; k < 12; k++) begin
            ld12Valid = 1'b1;
            ld12Data  = vt[k];
            step();
        end
        ld12Valid = 1'b0;
        check("n12_vv_lag", vv12, 0);
        step();
        check("n12_vv", vv12, 1);
        col12 = 4'd11;
        #1;
        check("n12_addr11", iv12, vt[11]);
        col12 = 4'd15;
        #1;
        check("n12_addr15", iv12, 0);
        col12 = 4'd12;
        #1;
        check("n12_addr12", iv12, 0);
        step();

`ifdef VECSERVER_STATS_EN
        check("stats_swapCount", swapCount, 3);
        check("stats_underrunCount", underrunCount, 1);
`endif

        // Asynchronous reset mid-fill (7 words of D in the shadow)
        for (int k = 0; k < 7; k++) load_word(vd[k]);
        colAddress = 4'd0;
        #3;
        reset = 1'b0;
        #1;
        check("async_rst_vv", vectorValid, 0);
        check("async_rst_iv", inputVector, 0);
        check("async_rst_underrun", underrun, 0);
        check("async_rst_state", fsmState, 0);
        check("async_rst_n12_vv", vv12, 0);
`ifdef VECSERVER_STATS_EN
        check("async_rst_swapCount", swapCount, 0);
        check("async_rst_underrunCount", underrunCount, 0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b1;
        step();

        // dataReady while EMPTY is ignored
        pulse_ready();
        check("empty_dr_underrun", underrun, 0);
        check("empty_dr_vv", vectorValid, 0);

        // Reload starts at element 0
        for (int k = 0; k < 16; k++) load_word(ve[k]);
        step();
        check("reload_vv", vectorValid, 1);
        push_vec(ve);
        sweep("sweep_e");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
